// File: rtl/uart_link.sv
// Full-duplex UART with RX/TX FIFOs, exposing valid/ready byte streams to the
// protocol handler and sticky framing/overrun error flags.
module uart_link #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rx_wire_in,
    output logic                        tx_wire_out,
    output logic [DATA_BITS-1:0]        rx_data_out,
    output logic                        rx_valid_out,
    input  logic                        rx_ready_in,
    input  logic [DATA_BITS-1:0]        tx_data_in,
    input  logic                        tx_valid_in,
    output logic                        tx_ready_out,
    output logic [$clog2(FIFO_DEPTH):0] rx_count_out,
    output logic [$clog2(FIFO_DEPTH):0] tx_count_out,
    output logic                        rx_frame_err_out,
    output logic                        rx_overrun_out,
    input  logic                        clear_err_in
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int CW           = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    // ---------------- RX synchroniser ----------------
    logic [1:0] rxSync_q;
    logic       rxLine;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) rxSync_q <= 2'b11;
        else        rxSync_q <= {rxSync_q[0], rx_wire_in};
    end

    assign rxLine = rxSync_q[1];

    // ---------------- RX FSM ----------------
    state_e               rxState_q, rxState_d;
    logic [TW-1:0]        rxTick_q, rxTick_d;
    logic [BW-1:0]        rxBit_q, rxBit_d;
    logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
    logic                 rxWaitHigh_q, rxWaitHigh_d;
    logic                 rxPush, rxFrameSet;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rxState_q    <= IDLE;
            rxTick_q     <= '0;
            rxBit_q      <= '0;
            rxShift_q    <= '0;
            rxWaitHigh_q <= 1'b0;
        end else begin
            rxState_q    <= rxState_d;
            rxTick_q     <= rxTick_d;
            rxBit_q      <= rxBit_d;
            rxShift_q    <= rxShift_d;
            rxWaitHigh_q <= rxWaitHigh_d;
        end
    end

    always_comb begin
        rxState_d    = rxState_q;
        rxTick_d     = rxTick_q;
        rxBit_d      = rxBit_q;
        rxShift_d    = rxShift_q;
        rxWaitHigh_d = rxWaitHigh_q;
        rxPush       = 1'b0;
        rxFrameSet   = 1'b0;
        unique case (rxState_q)
            IDLE: begin
                if (!rxLine) begin
                    rxState_d = START;
                    rxTick_d  = '0;
                end
            end
            START: begin
                // Re-check mid start bit; a line already back high was a glitch.
                if (rxTick_q == TW'(HALF_BIT - 1)) begin
                    rxTick_d  = '0;
                    rxBit_d   = '0;
                    rxState_d = rxLine ? IDLE : DATA;
                end else begin
                    rxTick_d = rxTick_q + 1'b1;
                end
            end
            DATA: begin
                if (rxTick_q == TW'(CLKS_PER_BIT - 1)) begin
                    rxTick_d  = '0;
                    rxShift_d = {rxLine, rxShift_q[DATA_BITS-1:1]};
                    if (rxBit_q == BW'(DATA_BITS - 1)) rxState_d = STOP;
                    else                               rxBit_d   = rxBit_q + 1'b1;
                end else begin
                    rxTick_d = rxTick_q + 1'b1;
                end
            end
            STOP: begin
                if (rxWaitHigh_q) begin
                    if (rxLine) begin
                        rxWaitHigh_d = 1'b0;
                        rxState_d    = IDLE;
                    end
                end else if (rxTick_q == TW'(CLKS_PER_BIT - 1)) begin
                    rxTick_d = '0;
                    if (rxLine) begin
                        rxPush    = 1'b1;
                        rxState_d = IDLE;
                    end else begin
                        rxFrameSet   = 1'b1;
                        rxWaitHigh_d = 1'b1;
                    end
                end else begin
                    rxTick_d = rxTick_q + 1'b1;
                end
            end
            default: rxState_d = IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rxMem [FIFO_DEPTH];
    logic [PW-1:0]        rxWr_q, rxRd_q;
    logic [CW-1:0]        rxCount_q, rxCount_d;
    logic                 rxPop, rxFull, rxWrite, rxOverrunSet;

    assign rxPop        = rx_valid_out & rx_ready_in;
    assign rxFull       = (rxCount_q == CW'(FIFO_DEPTH));
    assign rxWrite      = rxPush & (~rxFull | rxPop);
    assign rxOverrunSet = rxPush & rxFull & ~rxPop;

    always_comb begin
        rxCount_d = rxCount_q;
        case ({rxWrite, rxPop})
            2'b10:   rxCount_d = rxCount_q + 1'b1;
            2'b01:   rxCount_d = rxCount_q - 1'b1;
            default: rxCount_d = rxCount_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rxWr_q    <= '0;
            rxRd_q    <= '0;
            rxCount_q <= '0;
        end else begin
            if (rxWrite) rxWr_q <= rxWr_q + 1'b1;
            if (rxPop)   rxRd_q <= rxRd_q + 1'b1;
            rxCount_q <= rxCount_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rxWrite) rxMem[rxWr_q] <= rxShift_q;
    end

    assign rx_data_out  = rxMem[rxRd_q];
    assign rx_valid_out = (rxCount_q != '0);
    assign rx_count_out = rxCount_q;

    // ---------------- Sticky error flags (set wins over clear) ----------------
    logic frameErr_q, overrun_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            frameErr_q <= rxFrameSet   | (frameErr_q & ~clear_err_in);
            overrun_q  <= rxOverrunSet | (overrun_q  & ~clear_err_in);
        end
    end

    assign rx_frame_err_out = frameErr_q;
    assign rx_overrun_out   = overrun_q;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] txMem [FIFO_DEPTH];
    logic [PW-1:0]        txWr_q, txRd_q, txRdNext;
    logic [CW-1:0]        txCount_q, txCount_d;
    logic                 txPush, txPop;

    assign tx_ready_out = (txCount_q != CW'(FIFO_DEPTH));
    assign txPush       = tx_valid_in & tx_ready_out;
    assign txRdNext     = txRd_q + 1'b1;

    always_comb begin
        txCount_d = txCount_q;
        case ({txPush, txPop})
            2'b10:   txCount_d = txCount_q + 1'b1;
            2'b01:   txCount_d = txCount_q - 1'b1;
            default: txCount_d = txCount_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            txWr_q    <= '0;
            txRd_q    <= '0;
            txCount_q <= '0;
        end else begin
            if (txPush) txWr_q <= txWr_q + 1'b1;
            if (txPop)  txRd_q <= txRdNext;
            txCount_q <= txCount_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (txPush) txMem[txWr_q] <= tx_data_in;
    end

    assign tx_count_out = txCount_q;

    // ---------------- TX FSM ----------------
    state_e               txState_q, txState_d;
    logic [TW-1:0]        txTick_q, txTick_d;
    logic [BW-1:0]        txBit_q, txBit_d;
    logic [DATA_BITS-1:0] txShift_q, txShift_d;
    logic                 txLine_q, txLine_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            txState_q <= IDLE;
            txTick_q  <= '0;
            txBit_q   <= '0;
            txShift_q <= '0;
            txLine_q  <= 1'b1;
        end else begin
            txState_q <= txState_d;
            txTick_q  <= txTick_d;
            txBit_q   <= txBit_d;
            txShift_q <= txShift_d;
            txLine_q  <= txLine_d;
        end
    end

    always_comb begin
        txState_d = txState_q;
        txTick_d  = txTick_q;
        txBit_d   = txBit_q;
        txShift_d = txShift_q;
        txPop     = 1'b0;
        unique case (txState_q)
            IDLE: begin
                if (txCount_q != '0) begin
                    txState_d = START;
                    txTick_d  = '0;
                    txShift_d = txMem[txRd_q];
                end
            end
            START: begin
                if (txTick_q == TW'(CLKS_PER_BIT - 1)) begin
                    txTick_d  = '0;
                    txBit_d   = '0;
                    txState_d = DATA;
                end else begin
                    txTick_d = txTick_q + 1'b1;
                end
            end
            DATA: begin
                if (txTick_q == TW'(CLKS_PER_BIT - 1)) begin
                    txTick_d  = '0;
                    txShift_d = {1'b0, txShift_q[DATA_BITS-1:1]};
                    if (txBit_q == BW'(DATA_BITS - 1)) txState_d = STOP;
                    else                               txBit_d   = txBit_q + 1'b1;
                end else begin
                    txTick_d = txTick_q + 1'b1;
                end
            end
            STOP: begin
                // Chain straight into the next start bit so bursts have no idle gap.
                if (txTick_q == TW'(CLKS_PER_BIT - 1)) begin
                    txTick_d = '0;
                    txPop    = 1'b1;
                    if (txCount_q > CW'(1)) begin
                        txState_d = START;
                        txShift_d = txMem[txRdNext];
                    end else if (txPush) begin
                        txState_d = START;
                        txShift_d = tx_data_in;
                    end else begin
                        txState_d = IDLE;
                    end
                end else begin
                    txTick_d = txTick_q + 1'b1;
                end
            end
            default: txState_d = IDLE;
        endcase
    end

    always_comb begin
        txLine_d = 1'b1;
        case (txState_d)
            START:   txLine_d = 1'b0;
            DATA:    txLine_d = txShift_d[0];
            default: txLine_d = 1'b1;
        endcase
    end

    assign tx_wire_out = txLine_q;

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link at 10 clocks per bit, 4-deep FIFOs, 8 data bits;
// covers loopback, burst, overrun, framing error, glitch and mid-frame reset.
module tb_uart_link;

    localparam int CLK_HZ     = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxLine = 1'b1;
    logic       loopEn = 1'b0;
    logic       rxReady = 1'b0;
    logic       txValid = 1'b0;
    logic       clearErr = 1'b0;
    logic [7:0] txData = 8'h00;

    logic       txWire, rxWire, rxValid, txReady, frameErr, overrun;
    logic [7:0] rxData;
    logic [2:0] rxCount, txCount;

    int  total = 0;
    int  bad = 0;
    time txFallTime = 0;
    time pushT = 0;
    time t0 = 0;

    assign rxWire = loopEn ? txWire : rxLine;

    uart_link #(
        .CLK_HZ    (CLK_HZ),
        .BAUD_RATE (BAUD_RATE),
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .rx_wire_in      (rxWire),
        .tx_wire_out     (txWire),
        .rx_data_out     (rxData),
        .rx_valid_out    (rxValid),
        .rx_ready_in     (rxReady),
        .tx_data_in      (txData),
        .tx_valid_in     (txValid),
        .tx_ready_out    (txReady),
        .rx_count_out    (rxCount),
        .tx_count_out    (txCount),
        .rx_frame_err_out(frameErr),
        .rx_overrun_out  (overrun),
        .clear_err_in    (clearErr)
    );

    always #5 clk = ~clk;

    always @(negedge txWire) txFallTime = $time;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        txData  = d;
        txValid = 1'b1;
        @(posedge clk);
        pushT = $time;
        #1;
        txValid = 1'b0;
    endtask

    task automatic popRx();
        rxReady = 1'b1;
        waitCycles(1);
        rxReady = 1'b0;
    endtask

    task automatic pulseClear();
        clearErr = 1'b1;
        waitCycles(1);
        clearErr = 1'b0;
    endtask

    task automatic sendRxFrame(input logic [7:0] d, input logic stopBit);
        rxLine = 1'b0;
        waitCycles(10);
        for (int i = 0; i < 8; i++) begin
            rxLine = d[i];
            waitCycles(10);
        end
        rxLine = stopBit;
        waitCycles(10);
        rxLine = 1'b1;
        waitCycles(10);
    endtask

    // Samples each bit of a frame 1 unit past its centre clock edge.
    task automatic checkTxWord(input logic [7:0] d, input time start, input string tag);
        logic [9:0] frame;
        time        target;
        frame = {1'b1, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            target = start + time'(k * 100 + 51);
            if (target > $time) #(target - $time);
            checkOutput($sformatf("%s_bit%0d", tag, k), 32'(txWire), 32'(frame[k]));
        end
    endtask

    task automatic waitRxCount(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && rxCount != 3'(n); i++) waitCycles(1);
        checkOutput(tag, 32'(rxCount), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        waitCycles(3);
        checkOutput("rst_txwire", 32'(txWire), 32'(1));
        checkOutput("rst_rxvalid", 32'(rxValid), 32'(0));
        checkOutput("rst_txready", 32'(txReady), 32'(1));
        checkOutput("rst_rxcount", 32'(rxCount), 32'(0));
        checkOutput("rst_txcount", 32'(txCount), 32'(0));
        checkOutput("rst_frameerr", 32'(frameErr), 32'(0));
        checkOutput("rst_overrun", 32'(overrun), 32'(0));
        rst = 1'b0;
        waitCycles(2);

        // Loopback single byte 0xA5
        loopEn = 1'b1;
        applyStimulus(8'hA5);
        checkOutput("lb_txcount", 32'(txCount), 32'(1));
        waitCycles(2);
        checkOutput("lb_start_latency", 32'(txFallTime > pushT && (txFallTime - pushT) <= 20), 32'(1));
        checkTxWord(8'hA5, txFallTime, "lb");
        waitRxCount(1, 100, "lb_rxcount");
        checkOutput("lb_rxvalid", 32'(rxValid), 32'(1));
        checkOutput("lb_rxdata", 32'(rxData), 32'(8'hA5));
        popRx();
        waitCycles(10);
        checkOutput("lb_rxcount_end", 32'(rxCount), 32'(0));
        checkOutput("lb_txcount_end", 32'(txCount), 32'(0));
        checkOutput("lb_rxvalid_end", 32'(rxValid), 32'(0));

        // Burst 0x01..0x04, then one push against a full FIFO
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i));
        checkOutput("burst_txready_full", 32'(txReady), 32'(0));
        checkOutput("burst_txcount_full", 32'(txCount), 32'(4));
        applyStimulus(8'h99);
        checkOutput("burst_push_ignored", 32'(txCount), 32'(4));
        t0 = txFallTime;
        for (int w = 0; w < 4; w++) checkTxWord(8'(w + 1), t0 + time'(w * 1000), $sformatf("burst_w%0d", w));
        waitRxCount(4, 200, "burst_rxcount");
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("burst_rxdata%0d", i), 32'(rxData), 32'(i));
            popRx();
        end
        waitCycles(20);
        checkOutput("burst_txcount_end", 32'(txCount), 32'(0));
        checkOutput("burst_txready_end", 32'(txReady), 32'(1));
        checkOutput("burst_rxcount_end", 32'(rxCount), 32'(0));

        // Overrun: five frames into a 4-deep FIFO with no consumer
        loopEn = 1'b0;
        sendRxFrame(8'h11, 1'b1);
        sendRxFrame(8'h22, 1'b1);
        sendRxFrame(8'h33, 1'b1);
        sendRxFrame(8'h44, 1'b1);
        waitRxCount(4, 50, "ovr_rxcount_full");
        checkOutput("ovr_flag_before", 32'(overrun), 32'(0));
        sendRxFrame(8'h55, 1'b1);
        checkOutput("ovr_rxcount", 32'(rxCount), 32'(4));
        checkOutput("ovr_flag", 32'(overrun), 32'(1));
        checkOutput("ovr_head", 32'(rxData), 32'(8'h11));
        checkOutput("ovr_frameerr", 32'(frameErr), 32'(0));
        waitCycles(5);
        checkOutput("ovr_flag_sticky", 32'(overrun), 32'(1));
        pulseClear();
        checkOutput("ovr_flag_cleared", 32'(overrun), 32'(0));
        checkOutput("ovr_drain_d0", 32'(rxData), 32'(8'h11));
        popRx();
        checkOutput("ovr_drain_d1", 32'(rxData), 32'(8'h22));
        popRx();
        checkOutput("ovr_drain_d2", 32'(rxData), 32'(8'h33));
        popRx();
        checkOutput("ovr_drain_d3", 32'(rxData), 32'(8'h44));
        popRx();
        checkOutput("ovr_drained", 32'(rxValid), 32'(0));

        // Framing error: stop bit low, then a good frame
        sendRxFrame(8'h3C, 1'b0);
        checkOutput("fe_rxcount", 32'(rxCount), 32'(0));
        checkOutput("fe_flag", 32'(frameErr), 32'(1));
        sendRxFrame(8'h55, 1'b1);
        checkOutput("fe_next_valid", 32'(rxValid), 32'(1));
        checkOutput("fe_next_data", 32'(rxData), 32'(8'h55));
        checkOutput("fe_flag_sticky", 32'(frameErr), 32'(1));
        popRx();
        pulseClear();
        checkOutput("fe_flag_cleared", 32'(frameErr), 32'(0));

        // Glitch: 3-cycle low pulse
        rxLine = 1'b0;
        waitCycles(3);
        rxLine = 1'b1;
        waitCycles(40);
        checkOutput("gl_rxcount", 32'(rxCount), 32'(0));
        checkOutput("gl_frameerr", 32'(frameErr), 32'(0));
        checkOutput("gl_overrun", 32'(overrun), 32'(0));

        // Reset during data bit 3 of 0xC3, then transmit 0x7E
        loopEn = 1'b1;
        applyStimulus(8'hC3);
        waitCycles(2);
        t0 = txFallTime;
        if (t0 + 451 > $time) #(t0 + 451 - $time);
        checkOutput("rst_mid_line_low", 32'(txWire), 32'(0));
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_txwire", 32'(txWire), 32'(1));
        checkOutput("rst_mid_txcount", 32'(txCount), 32'(0));
        checkOutput("rst_mid_txready", 32'(txReady), 32'(1));
        checkOutput("rst_mid_rxcount", 32'(rxCount), 32'(0));
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2);
        applyStimulus(8'h7E);
        waitCycles(2);
        checkTxWord(8'h7E, txFallTime, "post_rst");
        waitRxCount(1, 100, "post_rst_rxcount");
        checkOutput("post_rst_rxdata", 32'(rxData), 32'(8'h7E));
        popRx();
        waitCycles(10);
        checkOutput("post_rst_txcount", 32'(txCount), 32'(0));
        checkOutput("post_rst_rxcount_end", 32'(rxCount), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
